// File: rtl/pixel_stream_gen_pkg.sv
// Shared encodings for the pixel stream source: pattern modes, one-hot FSM states and
// the running checksum step.
package pixel_stream_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_COORD = 2'd2,
    MODE_CHECK = 2'd3
  } mode_t;

  // One-hot so bench generators can decode the state from a single bit
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_GAP  = 3'b100
  } state_t;

  function automatic logic [31:0] csum_step(input logic [31:0] sum, input logic [31:0] pix);
    return {sum[30:0], sum[31]} ^ pix;
  endfunction

endpackage

// File: rtl/pixel_stream_gen_raster_counter.sv
// Raster x/y position: advances on each accepted transfer, wraps per line and frame.
// Next-position outputs are combinational; frame_end is a registered one-cycle pulse.
module raster_counter #(
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 9,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_clear,
  input  logic           i_adv,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic [X_W-1:0] o_nx_x,
  output logic [Y_W-1:0] o_nx_y,
  output logic           o_frame_end
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_frame_end;
  logic           w_eol;
  logic           w_eof;

  always_comb begin
    w_eol  = (r_x == X_LAST);
    w_eof  = w_eol && (r_y == Y_LAST);
    o_nx_x = w_eol ? '0 : r_x + 1'b1;
    o_nx_y = w_eof ? '0 : (w_eol ? r_y + 1'b1 : r_y);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= i_adv && w_eof;
      if (i_clear) begin
        r_x <= '0;
        r_y <= '0;
      end else if (i_adv) begin
        r_x <= o_nx_x;
        r_y <= o_nx_y;
      end
    end
  end

  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_frame_end = r_frame_end;

endmodule

// File: rtl/pixel_stream_gen.sv
// Pattern pixel source on the flag/done handshake with counted runs, gaps, abort and timeout.
// Defining CHECKSUM_EN adds a rotating-XOR checksum output over accepted pixels.
module pixel_stream_gen
  import pixel_stream_gen_pkg::*;
#(
  parameter int unsigned PIX_W   = 36,
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 9,
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned DELAY   = 2,
  parameter int unsigned REPS    = 1000,
  parameter int unsigned START   = 1,
  parameter int unsigned DEL     = 1,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             done,
  output logic             flag,
  output logic [PIX_W-1:0] pixel,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             busy,
  output logic             frame_end,
  output logic             run_done,
  output logic             timeout_err,
  output logic [31:0]      xfer_count
`ifdef CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  localparam logic [PIX_W-1:0] START_V  = PIX_W'(START);
  localparam logic [PIX_W-1:0] DEL_V    = PIX_W'(DEL);
  localparam logic [31:0]      LIMIT    = (REPS == 0) ? 32'(IMG_W * IMG_H) : 32'(REPS);
  localparam logic [31:0]      GAP_LAST = 32'(DELAY) - 32'd1;
  localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT) - 32'd1;

  state_t             r_state;
  state_t             w_next;
  mode_t              r_mode;
  logic [PIX_W-1:0]   r_pixel;
  logic [31:0]        r_xfer_count;
  logic [31:0]        r_to_cnt;
  logic [31:0]        r_gap;
  logic               r_run_done;
  logic               r_timeout_err;

  logic               w_accept;
  logic               w_start_acc;
  logic               w_last;
  logic               w_timeout;
  logic [X_W-1:0]     w_nx_x;
  logic [Y_W-1:0]     w_nx_y;
  logic [X_W+Y_W-1:0] w_coord;
  logic [PIX_W-1:0]   w_pix_next;
  logic [PIX_W-1:0]   w_pix_first;

  assign w_accept    = (r_state == ST_REQ) && done;
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_last      = (r_xfer_count + 32'd1) == LIMIT;
  assign w_timeout   = (r_state == ST_REQ) && !done && !abort && (TIMEOUT != 0) && (r_to_cnt == TO_LAST);

  raster_counter #(.X_W(X_W), .Y_W(Y_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_raster (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (w_start_acc),
    .i_adv       (w_accept),
    .o_x         (x),
    .o_y         (y),
    .o_nx_x      (w_nx_x),
    .o_nx_y      (w_nx_y),
    .o_frame_end (frame_end)
  );

  // Pattern value for the position the raster moves to on this acceptance
  always_comb begin
    w_coord     = {w_nx_y, w_nx_x};
    w_pix_next  = r_pixel;
    w_pix_first = (mode_t'(mode) == MODE_COORD) ? '0 : START_V;
    case (r_mode)
      MODE_RAMP:  w_pix_next = r_pixel + DEL_V;
      MODE_CONST: w_pix_next = START_V;
      MODE_COORD: w_pix_next = PIX_W'(w_coord);
      MODE_CHECK: w_pix_next = (w_nx_x[3] ^ w_nx_y[3]) ? ~START_V : START_V;
      default:    w_pix_next = r_pixel;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    flag   = (r_state == ST_REQ);
    busy   = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: if (start) w_next = ST_REQ;
      ST_REQ: begin
        if (abort)          w_next = ST_IDLE;
        else if (done)      w_next = w_last ? ST_IDLE : ((DELAY == 0) ? ST_REQ : ST_GAP);
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_GAP: begin
        if (abort)                 w_next = ST_IDLE;
        else if (r_gap == GAP_LAST) w_next = ST_REQ;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode        <= MODE_RAMP;
      r_pixel       <= START_V;
      r_xfer_count  <= '0;
      r_to_cnt      <= '0;
      r_gap         <= '0;
      r_run_done    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_run_done <= w_accept && w_last && !abort;
      r_to_cnt   <= ((r_state != ST_REQ) || done) ? 32'd0 : r_to_cnt + 32'd1;
      r_gap      <= (r_state == ST_GAP) ? r_gap + 32'd1 : 32'd0;
      if (w_start_acc) begin
        r_mode        <= mode_t'(mode);
        r_pixel       <= w_pix_first;
        r_xfer_count  <= '0;
        r_timeout_err <= 1'b0;
      end else if (w_accept) begin
        r_xfer_count <= r_xfer_count + 32'd1;
        r_pixel      <= w_pix_next;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign pixel       = r_pixel;
  assign run_done    = r_run_done;
  assign timeout_err = r_timeout_err;
  assign xfer_count  = r_xfer_count;

`ifdef CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clock) begin
    if (reset)            r_checksum <= '0;
    else if (w_start_acc) r_checksum <= '0;
    else if (w_accept)    r_checksum <= csum_step(r_checksum, 32'(r_pixel));
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench: a per-cycle vector table on a gapped instance, plus sequences for
// back-to-back full-frame coordinate runs and checkerboard / disabled-timeout runs.
module tb_pixel_stream_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: gapped, counted run, short timeout
  logic        rst_a, a_start, a_abort, a_done;
  logic [1:0]  a_mode;
  logic        a_flag, a_busy, a_fe, a_rd, a_terr;
  logic [35:0] a_pix;
  logic [3:0]  a_x, a_y;
  logic [31:0] a_xc;
  // Instance B: back-to-back full frame of 4x2
  logic        rst_bc, b_start, b_abort, b_done;
  logic [1:0]  b_mode;
  logic        b_flag, b_busy, b_fe, b_rd, b_terr;
  logic [35:0] b_pix;
  logic [3:0]  b_x, b_y;
  logic [31:0] b_xc;
  // Instance C: back-to-back 12 transfers, checkerboard, timeout disabled
  logic        c_start, c_abort, c_done;
  logic [1:0]  c_mode;
  logic        c_flag, c_busy, c_fe, c_rd, c_terr;
  logic [35:0] c_pix;
  logic [4:0]  c_x, c_y;
  logic [31:0] c_xc;
`ifdef CHECKSUM_EN
  logic [31:0] a_cs, b_cs, c_cs;
`endif

  pixel_stream_gen #(.PIX_W(36), .X_W(4), .Y_W(4), .IMG_W(4), .IMG_H(2), .DELAY(2),
                     .REPS(4), .START(1), .DEL(1), .TIMEOUT(5)) u_a (
    .clock(clock), .reset(rst_a), .start(a_start), .abort(a_abort), .mode(a_mode),
    .done(a_done), .flag(a_flag), .pixel(a_pix), .x(a_x), .y(a_y), .busy(a_busy),
    .frame_end(a_fe), .run_done(a_rd), .timeout_err(a_terr), .xfer_count(a_xc)
`ifdef CHECKSUM_EN
    , .checksum(a_cs)
`endif
  );

  pixel_stream_gen #(.PIX_W(36), .X_W(4), .Y_W(4), .IMG_W(4), .IMG_H(2), .DELAY(0),
                     .REPS(0), .START(1), .DEL(1), .TIMEOUT(5)) u_b (
    .clock(clock), .reset(rst_bc), .start(b_start), .abort(b_abort), .mode(b_mode),
    .done(b_done), .flag(b_flag), .pixel(b_pix), .x(b_x), .y(b_y), .busy(b_busy),
    .frame_end(b_fe), .run_done(b_rd), .timeout_err(b_terr), .xfer_count(b_xc)
`ifdef CHECKSUM_EN
    , .checksum(b_cs)
`endif
  );

  pixel_stream_gen #(.PIX_W(36), .X_W(5), .Y_W(5), .IMG_W(16), .IMG_H(16), .DELAY(0),
                     .REPS(12), .START(5), .DEL(1), .TIMEOUT(0)) u_c (
    .clock(clock), .reset(rst_bc), .start(c_start), .abort(c_abort), .mode(c_mode),
    .done(c_done), .flag(c_flag), .pixel(c_pix), .x(c_x), .y(c_y), .busy(c_busy),
    .frame_end(c_fe), .run_done(c_rd), .timeout_err(c_terr), .xfer_count(c_xc)
`ifdef CHECKSUM_EN
    , .checksum(c_cs)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, start, abort, done;
    logic [1:0] mode;
    logic flag, busy, rd, terr;
    logic [35:0] pix;
    logic [3:0] x, y;
    logic [31:0] xc;
  } vec_t;

  function automatic vec_t mk(input logic rst, st, ab, dn, input logic [1:0] md,
                              input logic fl, bz, rd, te, input logic [35:0] px,
                              input logic [3:0] xx, yy, input logic [31:0] xc);
    vec_t v;
    v.rst = rst; v.start = st; v.abort = ab; v.done = dn; v.mode = md;
    v.flag = fl; v.busy = bz; v.rd = rd; v.terr = te; v.pix = px;
    v.x = xx; v.y = yy; v.xc = xc;
    return v;
  endfunction

  localparam int NV = 34;
  vec_t tbl[NV];
  logic [35:0] b_exp_pix[8];

  initial begin
    // rst st ab dn md | flag busy rd terr pix x y xc  (outputs seen during that cycle)
    tbl[0]  = mk(0,1,0,1,0, 0,0,0,0, 1,0,0,0);   // start ramp; done in IDLE ignored
    tbl[1]  = mk(0,0,0,1,0, 1,1,0,0, 1,0,0,0);
    tbl[2]  = mk(0,0,0,1,0, 0,1,0,0, 2,1,0,1);   // GAP: done ignored
    tbl[3]  = mk(0,0,0,1,0, 0,1,0,0, 2,1,0,1);
    tbl[4]  = mk(0,0,0,1,0, 1,1,0,0, 2,1,0,1);
    tbl[5]  = mk(0,0,0,1,0, 0,1,0,0, 3,2,0,2);
    tbl[6]  = mk(0,0,0,1,0, 0,1,0,0, 3,2,0,2);
    tbl[7]  = mk(0,0,0,1,0, 1,1,0,0, 3,2,0,2);
    tbl[8]  = mk(0,0,0,1,0, 0,1,0,0, 4,3,0,3);
    tbl[9]  = mk(0,0,0,1,0, 0,1,0,0, 4,3,0,3);
    tbl[10] = mk(0,0,0,1,0, 1,1,0,0, 4,3,0,3);   // 4th transfer, line wraps
    tbl[11] = mk(0,0,0,1,0, 0,0,1,0, 5,0,1,4);   // run_done pulse
    tbl[12] = mk(0,1,0,0,0, 0,0,0,0, 5,0,1,4);
    tbl[13] = mk(0,0,0,1,0, 1,1,0,0, 1,0,0,0);
    tbl[14] = mk(0,0,0,0,0, 0,1,0,0, 2,1,0,1);
    tbl[15] = mk(0,0,0,0,0, 0,1,0,0, 2,1,0,1);
    tbl[16] = mk(0,0,1,1,0, 1,1,0,0, 2,1,0,1);   // done+abort on 2nd transfer
    tbl[17] = mk(0,1,0,0,1, 0,0,0,0, 3,2,0,2);   // restart in constant mode
    tbl[18] = mk(0,0,0,1,0, 1,1,0,0, 1,0,0,0);
    tbl[19] = mk(0,1,0,0,2, 0,1,0,0, 1,1,0,1);   // start while busy ignored
    tbl[20] = mk(0,0,0,0,0, 0,1,0,0, 1,1,0,1);
    tbl[21] = mk(0,0,1,0,0, 1,1,0,0, 1,1,0,1);   // abort in REQ
    tbl[22] = mk(0,1,0,0,0, 0,0,0,0, 1,1,0,1);
    for (int i = 23; i < 28; i++)
      tbl[i] = mk(0,0,0,0,0, 1,1,0,0, 1,0,0,0);  // 5 REQ cycles without done
    tbl[28] = mk(0,1,0,0,0, 0,0,0,1, 1,0,0,0);   // timed out, no run_done
    tbl[29] = mk(0,0,0,1,0, 1,1,0,0, 1,0,0,0);   // start cleared timeout_err
    tbl[30] = mk(1,0,0,0,0, 0,1,0,0, 2,1,0,1);   // reset asserted mid-GAP
    tbl[31] = mk(0,0,0,1,0, 0,0,0,0, 1,0,0,0);
    tbl[32] = mk(0,0,0,1,0, 0,0,0,0, 1,0,0,0);
    tbl[33] = mk(0,0,0,1,0, 0,0,0,0, 1,0,0,0);

    b_exp_pix = '{36'd0, 36'd1, 36'd2, 36'd3, 36'd16, 36'd17, 36'd18, 36'd19};

    rst_a = 1; rst_bc = 1;
    a_start = 0; a_abort = 0; a_done = 0; a_mode = 0;
    b_start = 0; b_abort = 0; b_done = 0; b_mode = 0;
    c_start = 0; c_abort = 0; c_done = 0; c_mode = 0;
    repeat (3) @(negedge clock);
    rst_a = 0; rst_bc = 0;
    @(negedge clock);
    chk("rst a pixel", a_pix, 36'd1);
    chk("rst a flag/busy", {a_flag, a_busy, a_rd, a_terr, a_fe}, 5'b0);
    chk("rst a xy", {a_x, a_y}, 8'd0);
    chk("rst a xfer_count", a_xc, 32'd0);
    chk("rst b flag/busy", {b_flag, b_busy, b_rd, b_terr, b_fe}, 5'b0);
    chk("rst c pixel", c_pix, 36'd5);
    chk("rst c xfer_count", c_xc, 32'd0);

    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clock);
      rst_a = tbl[i].rst; a_start = tbl[i].start; a_abort = tbl[i].abort;
      a_done = tbl[i].done; a_mode = tbl[i].mode;
      chk($sformatf("row%0d flag", i), a_flag, tbl[i].flag);
      chk($sformatf("row%0d busy", i), a_busy, tbl[i].busy);
      chk($sformatf("row%0d run_done", i), a_rd, tbl[i].rd);
      chk($sformatf("row%0d timeout_err", i), a_terr, tbl[i].terr);
      chk($sformatf("row%0d pixel", i), a_pix, tbl[i].pix);
      chk($sformatf("row%0d x", i), a_x, tbl[i].x);
      chk($sformatf("row%0d y", i), a_y, tbl[i].y);
      chk($sformatf("row%0d xfer_count", i), a_xc, tbl[i].xc);
      chk($sformatf("row%0d frame_end", i), a_fe, 1'b0);
    end
    @(negedge clock);
    a_done = 0;

    // B: one full 4x2 frame of {y,x} with done held high
    b_start = 1; b_mode = 2; b_done = 1;
    @(negedge clock);
    b_start = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b%0d flag", i), b_flag, 1'b1);
      chk($sformatf("b%0d x", i), b_x, 4'(i % 4));
      chk($sformatf("b%0d y", i), b_y, 4'(i / 4));
      chk($sformatf("b%0d pixel", i), b_pix, b_exp_pix[i]);
      chk($sformatf("b%0d frame_end", i), b_fe, 1'b0);
      @(negedge clock);
    end
    chk("b end flag/busy", {b_flag, b_busy}, 2'b00);
    chk("b end frame_end+run_done", {b_fe, b_rd}, 2'b11);
    chk("b end xfer_count", b_xc, 32'd8);
    chk("b end xy", {b_x, b_y}, 8'd0);
    chk("b end timeout_err", b_terr, 1'b0);
    b_done = 0;
    @(negedge clock);
    chk("b pulses drop", {b_fe, b_rd}, 2'b00);

    // C: 12 back-to-back checkerboard transfers along row 0
    c_start = 1; c_mode = 3; c_done = 1;
    @(negedge clock);
    c_start = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("c%0d flag", i), c_flag, 1'b1);
      chk($sformatf("c%0d x", i), c_x, 5'(i));
      chk($sformatf("c%0d y", i), c_y, 5'd0);
      chk($sformatf("c%0d pixel", i), c_pix, (i >= 8) ? 36'hFFFFFFFFA : 36'd5);
      @(negedge clock);
    end
    chk("c end flag/busy", {c_flag, c_busy}, 2'b00);
    chk("c end run_done", c_rd, 1'b1);
    chk("c end frame_end", c_fe, 1'b0);
    chk("c end xfer_count", c_xc, 32'd12);
    chk("c end x", c_x, 5'd12);

    // C: timeout disabled, request waits indefinitely until aborted
    c_done = 0; c_start = 1; c_mode = 0;
    @(negedge clock);
    c_start = 0;
    repeat (30) @(negedge clock);
    chk("c hold flag", c_flag, 1'b1);
    chk("c hold timeout_err", c_terr, 1'b0);
    chk("c hold pixel", c_pix, 36'd5);
    c_abort = 1;
    @(negedge clock);
    c_abort = 0;
    chk("c abort flag/busy", {c_flag, c_busy}, 2'b00);
    chk("c abort run_done", c_rd, 1'b0);
    chk("c abort xfer_count", c_xc, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
